// File: rtl/spi_arbiter_pkg.sv
// Shared types and constants for the SPI response arbiter.
package spi_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARBITRATE,
        LOCKED
    } arb_state_e;

    localparam logic [3:0] GRANT_NONE             = 4'hF;
    localparam int         MAX_REQUESTERS         = 8;
    localparam logic [7:0] DEFAULT_STATUS_ADDRESS = 8'hDC;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin choice: first set valid bit above last_grant, wrapping.
module round_robin_picker
    import spi_arbiter_pkg::*;
#(
    parameter int REQUESTERS = 4
) (
    input  logic [REQUESTERS-1:0] valid,
    input  logic [3:0]            last_grant,
    output logic [3:0]            next_index,
    output logic                  any,
    output logic                  multiple
);

    int distance;
    int best_distance;

    // Distance 0 is the source just after last_grant; the smallest distance wins.
    always_comb begin
        next_index    = GRANT_NONE;
        best_distance = REQUESTERS;
        distance      = 0;
        for (int i = 0; i < REQUESTERS; i++) begin
            distance = (i + 2 * REQUESTERS - int'(last_grant) - 1) % REQUESTERS;
            if (valid[i] && (distance < best_distance)) begin
                best_distance = distance;
                next_index    = 4'(i);
            end
        end
    end

    assign any      = |valid;
    assign multiple = ($countones(valid) > 1);

endmodule

// File: rtl/spi_response_arbiter.sv
// Grants one SPI response source per transaction and serves a read-to-clear
// collision counter at STATUS_ADDRESS.
//
// state     | meaning
// IDLE      | no transaction, outputs parked
// ARBITRATE | transaction open, waiting for a responder or status opcode
// LOCKED    | grant fixed, granted source passed through until deselect
module spi_response_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int         REQUESTERS     = 4,
    parameter logic [7:0] STATUS_ADDRESS = DEFAULT_STATUS_ADDRESS
) (
    input  logic                    clock_in,
    input  logic                    reset_n_in,
    input  logic [7:0]              opcode_in,
    input  logic                    opcode_valid_in,
    input  logic [8*REQUESTERS-1:0] response_in,
    input  logic [REQUESTERS-1:0]   response_valid_in,
    output logic [7:0]              response_out,
    output logic                    response_valid_out,
    output logic [3:0]              grant_out,
    output logic                    collision_out
);

    localparam logic [3:0] INTERNAL_GRANT = 4'(REQUESTERS);

    arb_state_e state_q, state_d;
    logic [3:0] last_grant_q, last_grant_d;
    logic [7:0] collision_count_q, collision_count_d;
    logic       collision_d;
    logic [3:0] grant_d;
    logic [7:0] response_d;
    logic       response_valid_d;

    logic [3:0] pick_index;
    logic       pick_any;
    logic       pick_multiple;
    logic [3:0] sel_index;
    logic [7:0] sel_byte;
    logic       sel_valid;
    logic       status_opcode;

    round_robin_picker #(.REQUESTERS(REQUESTERS)) u_picker (
        .valid      (response_valid_in),
        .last_grant (last_grant_q),
        .next_index (pick_index),
        .any        (pick_any),
        .multiple   (pick_multiple)
    );

    assign status_opcode = (opcode_in == STATUS_ADDRESS);

    // One mux serves both the fresh pick and the locked grant.
    always_comb begin
        sel_index = (state_q == LOCKED) ? grant_out : pick_index;
        sel_byte  = '0;
        sel_valid = 1'b0;
        for (int k = 0; k < REQUESTERS; k++) begin
            if (sel_index == 4'(k)) begin
                sel_byte  = response_in[8*k +: 8];
                sel_valid = response_valid_in[k];
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            state_q            <= IDLE;
            last_grant_q       <= 4'(REQUESTERS - 1);
            collision_count_q  <= '0;
            collision_out      <= 1'b0;
            grant_out          <= GRANT_NONE;
            response_out       <= '0;
            response_valid_out <= 1'b0;
        end else begin
            state_q            <= state_d;
            last_grant_q       <= last_grant_d;
            collision_count_q  <= collision_count_d;
            collision_out      <= collision_d;
            grant_out          <= grant_d;
            response_out       <= response_d;
            response_valid_out <= response_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (opcode_valid_in) state_d = ARBITRATE;
            ARBITRATE: if (status_opcode || pick_any) state_d = LOCKED;
            LOCKED:    state_d = LOCKED;
            default:   state_d = IDLE;
        endcase
        if (!opcode_valid_in) state_d = IDLE;
    end

    always_comb begin
        grant_d           = GRANT_NONE;
        response_d        = '0;
        response_valid_d  = 1'b0;
        last_grant_d      = last_grant_q;
        collision_count_d = collision_count_q;
        collision_d       = collision_out;
        if (opcode_valid_in) begin
            unique case (state_q)
                ARBITRATE: begin
                    if (status_opcode) begin
                        grant_d          = INTERNAL_GRANT;
                        response_d       = collision_count_q;
                        response_valid_d = 1'b1;
                    end else if (pick_any) begin
                        grant_d          = pick_index;
                        last_grant_d     = pick_index;
                        response_d       = sel_byte;
                        response_valid_d = sel_valid;
                        if (pick_multiple) begin
                            collision_count_d = sat_inc8(collision_count_q);
                            collision_d       = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    grant_d = grant_out;
                    if (grant_out == INTERNAL_GRANT) begin
                        response_d       = collision_count_q;
                        response_valid_d = 1'b1;
                    end else begin
                        response_d       = sel_byte;
                        response_valid_d = sel_valid;
                    end
                end
                default: ;
            endcase
        end
        // Read-to-clear applied last so it overrides any same-cycle collision.
        if (!opcode_valid_in && (state_q == LOCKED) && (grant_out == INTERNAL_GRANT)) begin
            collision_count_d = '0;
            collision_d       = 1'b0;
        end
    end

endmodule
